// File: rtl/reg_sweep_pkg.sv
// Shared types and LFSR helper for the register sweep driver.
package reg_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_CHK  = 3'd4,
        S_FIN  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        M_WR    = 2'd0,
        M_WRRD  = 2'd1,
        M_INTLV = 2'd2
    } mode_e;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // Mode code 3 has no meaning of its own and runs as a plain write sweep
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'd1:    r = M_WRRD;
            2'd2:    r = M_INTLV;
            default: r = M_WR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sweep_lfsr.sv
// Seeded 32-bit LFSR with reload and step; reload and step in the same cycle
// yields the first successor of the seed.
module sweep_lfsr
    import reg_sweep_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] value_r;
    logic [31:0] base_s;
    logic [31:0] value_s;

    // Next LFSR value from the optional reload followed by the optional step
    always_comb begin
        base_s  = value_r;
        value_s = value_r;
        if (load) begin
            base_s = SEED;
        end else begin
            base_s = value_r;
        end
        if (advance) begin
            value_s = lfsr_step(base_s);
        end else begin
            value_s = base_s;
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_r <= SEED;
        end else begin
            value_r <= value_s;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/reg_sweep_driver.sv
// Register-bus sweep generator: writes an LFSR pattern across a strided
// address range and optionally reads each register back and checks it.
module reg_sweep_driver
    import reg_sweep_pkg::*;
#(
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        REQ_W    = 2,
    parameter int unsigned        NUM_REGS = 64,
    parameter int unsigned        STRIDE   = 4,
    parameter logic [ADDR_W-1:0]  BASE     = {ADDR_W{1'b0}},
    parameter int unsigned        RD_LAT   = 1,
    parameter logic [31:0]        SEED     = 32'hACE1_2468,
    parameter logic [DATA_W-1:0]  CHK_MASK = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [REQ_W-1:0]  req,
    output logic              wnr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err
);

    localparam int unsigned       IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam int unsigned       LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);
    localparam logic [DATA_W-1:0] SEED_D   = DATA_W'(SEED);

    state_e              state_r, state_s;
    mode_e               mode_r, mode_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [LAT_W-1:0]    lat_r, lat_s;
    logic [ADDR_W-1:0]   address_r, address_s;
    logic [REQ_W-1:0]    req_r, req_s;
    logic                wnr_r, wnr_s;
    logic [DATA_W-1:0]   data_out_r, data_out_s;
    logic [DATA_W-1:0]   hold_r, hold_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [15:0]         err_count_r, err_count_s;
    logic [ADDR_W-1:0]   first_err_r, first_err_s;

    logic                wr_load_s, wr_adv_s, exp_load_s, exp_adv_s;
    logic [31:0]         wr_value, exp_value;
    logic [DATA_W-1:0]   expected_s;
    logic                mism_s;

    // Write data source: holds the next value to be put on data_out
    sweep_lfsr #(.SEED(SEED)) u_wr_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_load_s),
        .advance (wr_adv_s),
        .value   (wr_value)
    );

    // Expected-value source for the write-all-then-read-all readback pass
    sweep_lfsr #(.SEED(SEED)) u_exp_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (exp_load_s),
        .advance (exp_adv_s),
        .value   (exp_value)
    );

    // Readback comparison against the expected value, restricted to checked bits
    always_comb begin
        expected_s = exp_value[DATA_W-1:0];
        if (mode_r == M_INTLV) begin
            expected_s = hold_r;
        end else begin
            expected_s = exp_value[DATA_W-1:0];
        end
        mism_s = |((rd_data ^ expected_s) & CHK_MASK);
    end

    // Next-state and next-output logic; bus outputs are computed for the cycle being entered
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        idx_s       = idx_r;
        lat_s       = lat_r;
        address_s   = address_r;
        req_s       = {REQ_W{1'b0}};
        wnr_s       = 1'b0;
        data_out_s  = data_out_r;
        hold_s      = hold_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        err_count_s = err_count_r;
        first_err_s = first_err_r;
        wr_load_s   = 1'b0;
        wr_adv_s    = 1'b0;
        exp_load_s  = 1'b0;
        exp_adv_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s     = S_WR;
                    mode_s      = decode_mode(mode);
                    idx_s       = {IDX_W{1'b0}};
                    address_s   = BASE;
                    req_s       = {REQ_W{1'b1}};
                    wnr_s       = 1'b1;
                    data_out_s  = SEED_D;
                    busy_s      = 1'b1;
                    err_count_s = 16'd0;
                    first_err_s = {ADDR_W{1'b0}};
                    wr_load_s   = 1'b1;
                    wr_adv_s    = 1'b1;
                    exp_load_s  = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR: begin
                hold_s = data_out_r;
                if (mode_r == M_INTLV) begin
                    state_s = S_RD;
                    req_s   = {REQ_W{1'b1}};
                end else if (idx_r != LAST_IDX) begin
                    idx_s      = idx_r + IDX_ONE;
                    address_s  = address_r + STEP;
                    req_s      = {REQ_W{1'b1}};
                    wnr_s      = 1'b1;
                    data_out_s = wr_value[DATA_W-1:0];
                    wr_adv_s   = 1'b1;
                end else if (mode_r == M_WRRD) begin
                    state_s    = S_RD;
                    idx_s      = {IDX_W{1'b0}};
                    address_s  = BASE;
                    req_s      = {REQ_W{1'b1}};
                    exp_load_s = 1'b1;
                end else begin
                    state_s = S_FIN;
                end
            end
            S_RD: begin
                if (RD_LAT == 1) begin
                    state_s = S_CHK;
                end else begin
                    state_s = S_WAIT;
                    lat_s   = LAT_INIT;
                end
            end
            S_WAIT: begin
                if (lat_r <= LAT_ONE) begin
                    state_s = S_CHK;
                end else begin
                    lat_s = lat_r - LAT_ONE;
                end
            end
            S_CHK: begin
                exp_adv_s = 1'b1;
                if (mism_s) begin
                    if (err_count_r != 16'hFFFF) begin
                        err_count_s = err_count_r + 16'd1;
                    end else begin
                        err_count_s = err_count_r;
                    end
                    if (err_count_r == 16'd0) begin
                        first_err_s = address_r;
                    end else begin
                        first_err_s = first_err_r;
                    end
                end else begin
                    err_count_s = err_count_r;
                end
                if (idx_r == LAST_IDX) begin
                    state_s = S_FIN;
                end else begin
                    idx_s     = idx_r + IDX_ONE;
                    address_s = address_r + STEP;
                    req_s     = {REQ_W{1'b1}};
                    if (mode_r == M_INTLV) begin
                        state_s    = S_WR;
                        wnr_s      = 1'b1;
                        data_out_s = wr_value[DATA_W-1:0];
                        wr_adv_s   = 1'b1;
                    end else begin
                        state_s = S_RD;
                    end
                end
            end
            S_FIN: begin
                state_s = S_IDLE;
                done_s  = 1'b1;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            mode_r      <= M_WR;
            idx_r       <= {IDX_W{1'b0}};
            lat_r       <= {LAT_W{1'b0}};
            address_r   <= BASE;
            req_r       <= {REQ_W{1'b0}};
            wnr_r       <= 1'b0;
            data_out_r  <= {DATA_W{1'b0}};
            hold_r      <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_count_r <= 16'd0;
            first_err_r <= {ADDR_W{1'b0}};
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            idx_r       <= idx_s;
            lat_r       <= lat_s;
            address_r   <= address_s;
            req_r       <= req_s;
            wnr_r       <= wnr_s;
            data_out_r  <= data_out_s;
            hold_r      <= hold_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_count_r <= err_count_s;
            first_err_r <= first_err_s;
        end
    end

    assign req       = req_r;
    assign wnr       = wnr_r;
    assign address   = address_r;
    assign data_out  = data_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_count = err_count_r;
    assign first_err = first_err_r;

endmodule

// File: tb/tb_reg_sweep_driver.sv
// Directed bench for reg_sweep_driver: three instances with behavioural register models.
module tb_reg_sweep_driver;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] mode;
    logic start0, start1, start2;
    logic stuck, flip, clr;

    logic [1:0]  req0, req1, req2;
    logic        wnr0, wnr1, wnr2;
    logic [7:0]  addr0, addr1, addr2;
    logic [31:0] dout0, dout1, dout2;
    logic [31:0] rd0, rd1, rd2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] errc0, errc1, errc2;
    logic [7:0]  ferr0, ferr1, ferr2;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] p0, p1, p2;
    logic [31:0] vexp [80];

    logic [7:0]  la0 [256];
    logic [31:0] ld0 [256];
    logic [7:0]  ra0 [256];
    logic [7:0]  la1 [256];
    logic [31:0] ld1 [256];
    logic [7:0]  ra1 [256];
    logic [7:0]  la2 [256];
    logic [31:0] ld2 [256];
    int wc0, rc0, bad0, wc1, rc1, bad1, wc2, rc2, bad2;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    logic [31:0] e_err;

    always #5 clk = ~clk;

    reg_sweep_driver u0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode),
        .req(req0), .wnr(wnr0), .address(addr0), .data_out(dout0), .rd_data(rd0),
        .busy(busy0), .done(done0), .err_count(errc0), .first_err(ferr0)
    );

    reg_sweep_driver #(.RD_LAT(3), .CHK_MASK(32'hFFFF_FF00)) u1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode),
        .req(req1), .wnr(wnr1), .address(addr1), .data_out(dout1), .rd_data(rd1),
        .busy(busy1), .done(done1), .err_count(errc1), .first_err(ferr1)
    );

    reg_sweep_driver #(.NUM_REGS(80)) u2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode),
        .req(req2), .wnr(wnr2), .address(addr2), .data_out(dout2), .rd_data(rd2),
        .busy(busy2), .done(done2), .err_count(errc2), .first_err(ferr2)
    );

    assign rd2 = 32'd0;
    assign rd1 = p2;

    // Register set for u0: one-cycle read latency, optional stuck-at-0 on bit 0 of 0x28
    always @(posedge clk) begin
        if (req0 == 2'b11 && wnr0)
            mem0[addr0] <= (stuck && addr0 == 8'h28) ? (dout0 & 32'hFFFF_FFFE) : dout0;
        if (req0 == 2'b11 && !wnr0)
            rd0 <= mem0[addr0];
    end

    // Register set for u1: three-cycle read latency, low byte always corrupted,
    // optional bit-8 flip at 0x10
    always @(posedge clk) begin
        if (req1 == 2'b11 && wnr1)
            mem1[addr1] <= dout1;
        p0 <= mem1[addr1] ^ 32'h0000_00A5 ^ ((flip && addr1 == 8'h10) ? 32'h0000_0100 : 32'h0);
        p1 <= p0;
        p2 <= p1;
    end

    // Bus monitors (sampled mid-cycle)
    always @(negedge clk) begin
        if (clr) begin
            wc0 <= 0; rc0 <= 0; bad0 <= 0;
        end else if (req0 == 2'b11) begin
            if (wnr0) begin la0[wc0[7:0]] <= addr0; ld0[wc0[7:0]] <= dout0; wc0 <= wc0 + 1; end
            else begin ra0[rc0[7:0]] <= addr0; rc0 <= rc0 + 1; end
        end else if (req0 != 2'b00) bad0 <= bad0 + 1;
    end

    always @(negedge clk) begin
        if (clr) begin
            wc1 <= 0; rc1 <= 0; bad1 <= 0;
        end else if (req1 == 2'b11) begin
            if (wnr1) begin la1[wc1[7:0]] <= addr1; ld1[wc1[7:0]] <= dout1; wc1 <= wc1 + 1; end
            else begin ra1[rc1[7:0]] <= addr1; rc1 <= rc1 + 1; end
        end else if (req1 != 2'b00) bad1 <= bad1 + 1;
    end

    always @(negedge clk) begin
        if (clr) begin
            wc2 <= 0; rc2 <= 0; bad2 <= 0;
        end else if (req2 == 2'b11) begin
            if (wnr2) begin la2[wc2[7:0]] <= addr2; ld2[wc2[7:0]] <= dout2; wc2 <= wc2 + 1; end
            else rc2 <= rc2 + 1;
        end else if (req2 != 2'b00) bad2 <= bad2 + 1;
    end

    // Reference sequence: Galois LFSR, taps 32,22,2,1 fed back into bits 31,21,1,0
    function automatic logic [31:0] tb_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n[31] = ~n[31];
            n[21] = ~n[21];
            n[1]  = ~n[1];
            n[0]  = ~n[0];
        end
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sel_done(input int inst);
        if (inst == 0) return done0;
        else if (inst == 1) return done1;
        else return done2;
    endfunction

    task automatic clear_logs();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    // Pulse start on one instance, count rising edges until done (edge 1 samples start)
    task automatic run_sweep(input int inst, input logic [1:0] m, input int budget, output int cycles);
        cycles = -1;
        @(negedge clk);
        mode = m;
        if (inst == 0) start0 = 1'b1;
        else if (inst == 1) start1 = 1'b1;
        else start2 = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
            if (sel_done(inst)) begin
                cycles = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", {31'd0, sel_done(inst)}, 32'd0);
    endtask

    task automatic check_reset0(input string tag);
        check_eq({tag, "_req"},  {30'd0, req0}, 32'd0);
        check_eq({tag, "_wnr"},  {31'd0, wnr0}, 32'd0);
        check_eq({tag, "_addr"}, {24'd0, addr0}, 32'd0);
        check_eq({tag, "_data"}, dout0, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy0}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done0}, 32'd0);
        check_eq({tag, "_errc"}, {16'd0, errc0}, 32'd0);
        check_eq({tag, "_ferr"}, {24'd0, ferr0}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; mode = 2'd0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        stuck = 1'b0; flip = 1'b0; clr = 1'b0;
        vexp[0] = 32'hACE1_2468;
        for (int k = 1; k < 80; k++) vexp[k] = tb_next(vexp[k-1]);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset0("rst");
        reset = 1'b1;

        // mode 0: 64 writes, done after 66 edges
        clear_logs();
        run_sweep(0, 2'd0, 300, cyc);
        check_eq("m0_len", cyc, 32'd66);
        check_eq("m0_writes", wc0, 32'd64);
        check_eq("m0_reads", rc0, 32'd0);
        check_eq("m0_badreq", bad0, 32'd0);
        for (int k = 0; k < 64; k++) begin
            check_eq("m0_addr", {24'd0, la0[k]}, k * 4);
            check_eq("m0_data", ld0[k], vexp[k]);
        end
        check_eq("m0_busy_end", {31'd0, busy0}, 32'd0);

        // mode 3 behaves as mode 0
        clear_logs();
        run_sweep(0, 2'd3, 300, cyc);
        check_eq("m3_len", cyc, 32'd66);
        check_eq("m3_writes", wc0, 32'd64);
        check_eq("m3_reads", rc0, 32'd0);

        // mode 1, ideal registers; a start/mode change mid-run must be ignored
        clear_logs();
        fork
            run_sweep(0, 2'd1, 600, cyc);
            begin
                repeat (30) @(negedge clk);
                mode = 2'd0; start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
            end
        join
        check_eq("m1_len", cyc, 32'd194);
        check_eq("m1_writes", wc0, 32'd64);
        check_eq("m1_reads", rc0, 32'd64);
        check_eq("m1_rd_first", {24'd0, ra0[0]}, 32'h00);
        check_eq("m1_rd_10", {24'd0, ra0[10]}, 32'h28);
        check_eq("m1_rd_last", {24'd0, ra0[63]}, 32'hFC);
        check_eq("m1_errc", {16'd0, errc0}, 32'd0);
        check_eq("m1_ferr", {24'd0, ferr0}, 32'd0);
        check_eq("m1_badreq", bad0, 32'd0);

        // mode 1 with bit 0 of 0x28 stuck at 0
        stuck = 1'b1;
        e_err = {31'd0, vexp[10][0]};
        clear_logs();
        run_sweep(0, 2'd1, 600, cyc);
        stuck = 1'b0;
        check_eq("stuck_len", cyc, 32'd194);
        check_eq("stuck_errc", {16'd0, errc0}, e_err);
        check_eq("stuck_ferr", {24'd0, ferr0}, e_err[0] ? 32'h28 : 32'h0);

        // reset during a mode 1 run, then a full run from BASE
        clear_logs();
        @(negedge clk);
        mode = 2'd1; start0 = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1 start0 = 1'b0;
        end
        check_eq("abort_busy", {31'd0, busy0}, 32'd1);
        check_eq("abort_req", {30'd0, req0}, 32'd3);
        check_eq("abort_addr", {24'd0, addr0}, 32'h4C);
        check_eq("abort_errc_cleared", {16'd0, errc0}, 32'd0);
        check_eq("abort_ferr_cleared", {24'd0, ferr0}, 32'd0);
        reset = 1'b0;
        #1;
        check_reset0("abort");
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_done", {31'd0, done0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        run_sweep(0, 2'd1, 600, cyc);
        check_eq("rerun_len", cyc, 32'd194);
        check_eq("rerun_writes", wc0, 32'd64);
        check_eq("rerun_addr0", {24'd0, la0[0]}, 32'h00);
        check_eq("rerun_data0", ld0[0], vexp[0]);
        check_eq("rerun_errc", {16'd0, errc0}, 32'd0);

        // mode 2, RD_LAT=3, low byte masked out of the check
        clear_logs();
        run_sweep(1, 2'd2, 1000, cyc);
        check_eq("m2_len", cyc, 32'd322);
        check_eq("m2_writes", wc1, 32'd64);
        check_eq("m2_reads", rc1, 32'd64);
        check_eq("m2_rd5", {24'd0, ra1[5]}, 32'h14);
        check_eq("m2_data0", ld1[0], vexp[0]);
        check_eq("m2_data63", ld1[63], vexp[63]);
        check_eq("m2_errc", {16'd0, errc1}, 32'd0);
        check_eq("m2_badreq", bad1, 32'd0);

        // mode 2 with a checked bit flipped at 0x10
        flip = 1'b1;
        clear_logs();
        run_sweep(1, 2'd2, 1000, cyc);
        flip = 1'b0;
        check_eq("m2f_len", cyc, 32'd322);
        check_eq("m2f_errc", {16'd0, errc1}, 32'd1);
        check_eq("m2f_ferr", {24'd0, ferr1}, 32'h10);

        // 80 registers: address wraps 0xFC -> 0x00 silently
        clear_logs();
        run_sweep(2, 2'd0, 300, cyc);
        check_eq("wrap_len", cyc, 32'd82);
        check_eq("wrap_writes", wc2, 32'd80);
        check_eq("wrap_reads", rc2, 32'd0);
        check_eq("wrap_a63", {24'd0, la2[63]}, 32'hFC);
        check_eq("wrap_a64", {24'd0, la2[64]}, 32'h00);
        check_eq("wrap_a79", {24'd0, la2[79]}, 32'h3C);
        check_eq("wrap_d79", ld2[79], vexp[79]);
        check_eq("wrap_errc", {16'd0, errc2}, 32'd0);
        check_eq("wrap_ferr", {24'd0, ferr2}, 32'd0);
        check_eq("wrap_badreq", bad2, 32'd0);
        check_eq("wrap_busy_end", {31'd0, busy2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
